multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-subset controller: instruction sequencing FSM plus a retired-instruction counter.
// Define MCTRL_ILLEGAL_TRAP_EN to trap illegal instructions into HALT; otherwise they retire as NOPs.
//
// state  | code | meaning
// FETCH  | 0    | latch instruction (IRWr)
// DECODE | 1    | dispatch on OP/Funct
// EXE    | 2    | drive ALU controls for R-type/ori/lw/sw
// MEM_RD | 3    | wait for dm_ready on a load
// MEM_WB | 4    | write load data to rt, advance PC
// MEM_WR | 5    | store, held until dm_ready
// ALU_WB | 6    | write ALU result, advance PC
// BRANCH | 7    | beq compare and PC update
// JUMP   | 8    | j/jal PC update (jal links $31)
// HALT   | 9    | illegal instruction trap, left only by reset
module multicycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       OP,
    input  logic [5:0]       Funct,
    input  logic             Zero,
    input  logic             dm_ready,
    output logic             PCWr,
    output logic             IRWr,
    output logic             RFWr,
    output logic             DMWr,
    output logic             BSel,
    output logic [1:0]       WDSel,
    output logic [1:0]       NPCOp,
    output logic [1:0]       EXTOp,
    output logic [1:0]       ALUOp,
    output logic [1:0]       GPRSel,
    output logic [3:0]       state_o,
    output logic [CNT_W-1:0] instr_cnt,
    output logic             halted
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        EXE    = 4'd2,
        MEM_RD = 4'd3,
        MEM_WB = 4'd4,
        MEM_WR = 4'd5,
        ALU_WB = 4'd6,
        BRANCH = 4'd7,
        JUMP   = 4'd8,
        HALT   = 4'd9
    } state_t;

    state_t state, state_next;
    logic   pc_wr, ir_wr, rf_wr, dm_wr;

    logic is_addu, is_subu, is_rtype, is_ori, is_lw, is_sw, is_beq, is_j, is_jal;

    assign is_addu  = (OP == 6'b000000) && (Funct == 6'b100001);
    assign is_subu  = (OP == 6'b000000) && (Funct == 6'b100011);
    assign is_rtype = is_addu || is_subu;
    assign is_ori   = (OP == 6'b001101);
    assign is_lw    = (OP == 6'b100011);
    assign is_sw    = (OP == 6'b101011);
    assign is_beq   = (OP == 6'b000100);
    assign is_j     = (OP == 6'b000010);
    assign is_jal   = (OP == 6'b000011);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FETCH;
            instr_cnt <= '0;
        end else begin
            state <= state_next;
            if (pc_wr)
                instr_cnt <= instr_cnt + CNT_W'(1);
        end
    end

`ifdef MCTRL_ILLEGAL_TRAP_EN
    always_ff @(posedge clk) begin
        if (rst)
            halted <= 1'b0;
        else if (state_next == HALT)
            halted <= 1'b1;
    end
`else
    assign halted = 1'b0;
`endif

    always_comb begin
        state_next = state;
        pc_wr      = 1'b0;
        ir_wr      = 1'b0;
        rf_wr      = 1'b0;
        dm_wr      = 1'b0;
        BSel       = 1'b0;
        WDSel      = 2'b00;
        NPCOp      = 2'b00;
        EXTOp      = 2'b00;
        ALUOp      = 2'b00;
        GPRSel     = 2'b00;
        case (state)
            FETCH: begin
                ir_wr      = 1'b1;
                state_next = DECODE;
            end
            DECODE: begin
                if (is_rtype || is_ori || is_lw || is_sw)
                    state_next = EXE;
                else if (is_beq)
                    state_next = BRANCH;
                else if (is_j || is_jal)
                    state_next = JUMP;
                else begin
`ifdef MCTRL_ILLEGAL_TRAP_EN
                    state_next = HALT;
`else
                    pc_wr      = 1'b1;
                    state_next = FETCH;
`endif
                end
            end
            EXE: begin
                if (is_rtype) begin
                    ALUOp      = is_subu ? 2'b01 : 2'b00;
                    state_next = ALU_WB;
                end else if (is_ori) begin
                    BSel       = 1'b1;
                    ALUOp      = 2'b10;
                    state_next = ALU_WB;
                end else begin
                    BSel       = 1'b1;
                    EXTOp      = 2'b01;
                    state_next = is_lw ? MEM_RD : MEM_WR;
                end
            end
            MEM_RD: begin
                if (dm_ready)
                    state_next = MEM_WB;
            end
            MEM_WB: begin
                rf_wr      = 1'b1;
                WDSel      = 2'b01;
                GPRSel     = 2'b01;
                pc_wr      = 1'b1;
                state_next = FETCH;
            end
            MEM_WR: begin
                dm_wr = 1'b1;
                if (dm_ready) begin
                    pc_wr      = 1'b1;
                    state_next = FETCH;
                end
            end
            ALU_WB: begin
                rf_wr      = 1'b1;
                GPRSel     = is_ori ? 2'b01 : 2'b00;
                pc_wr      = 1'b1;
                state_next = FETCH;
            end
            BRANCH: begin
                ALUOp      = 2'b01;
                EXTOp      = 2'b01;
                NPCOp      = Zero ? 2'b01 : 2'b00;
                pc_wr      = 1'b1;
                state_next = FETCH;
            end
            JUMP: begin
                NPCOp = 2'b10;
                pc_wr = 1'b1;
                if (is_jal) begin
                    rf_wr  = 1'b1;
                    WDSel  = 2'b10;
                    GPRSel = 2'b10;
                end
                state_next = FETCH;
            end
`ifdef MCTRL_ILLEGAL_TRAP_EN
            HALT: state_next = HALT;
`endif
            default: state_next = FETCH;
        endcase
    end

    // Write strobes are masked during reset so an interrupted access never commits.
    assign PCWr    = pc_wr && !rst;
    assign IRWr    = ir_wr && !rst;
    assign RFWr    = rf_wr && !rst;
    assign DMWr    = dm_wr && !rst;
    assign state_o = state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: randomized instruction streams against a latency/outcome model.
module tb_multicycle_ctrl;
    localparam int CW = 4;

    localparam int K_ADDU = 0, K_SUBU = 1, K_ORI = 2, K_LW = 3, K_SW = 4,
                   K_BEQ = 5, K_J = 6, K_JAL = 7, K_ILL = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [5:0]    OP, Funct;
    logic          Zero, dm_ready;
    logic          PCWr, IRWr, RFWr, DMWr, BSel;
    logic [1:0]    WDSel, NPCOp, EXTOp, ALUOp, GPRSel;
    logic [3:0]    state_o;
    logic [CW-1:0] instr_cnt;
    logic          halted;

    int n_tests = 0;
    int n_fail  = 0;
    int mcnt    = 0;
    int seen[$];

    multicycle_ctrl #(.CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .OP(OP), .Funct(Funct), .Zero(Zero), .dm_ready(dm_ready),
        .PCWr(PCWr), .IRWr(IRWr), .RFWr(RFWr), .DMWr(DMWr), .BSel(BSel),
        .WDSel(WDSel), .NPCOp(NPCOp), .EXTOp(EXTOp), .ALUOp(ALUOp), .GPRSel(GPRSel),
        .state_o(state_o), .instr_cnt(instr_cnt), .halted(halted)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int classify(input logic [5:0] op, input logic [5:0] fn);
        if (op == 6'd0 && fn == 6'b100001) return K_ADDU;
        if (op == 6'd0 && fn == 6'b100011) return K_SUBU;
        case (op)
            6'b001101: return K_ORI;
            6'b100011: return K_LW;
            6'b101011: return K_SW;
            6'b000100: return K_BEQ;
            6'b000010: return K_J;
            6'b000011: return K_JAL;
            default:   return K_ILL;
        endcase
    endfunction

    function automatic int latency(input int k, input int waits);
        case (k)
            K_BEQ, K_J, K_JAL:    return 3;
            K_ADDU, K_SUBU, K_ORI: return 4;
            K_SW:                 return 4 + waits;
            K_LW:                 return 5 + waits;
            default:              return 2;
        endcase
    endfunction

    function automatic logic [CW-1:0] cnt_of(input int c);
        return CW'(c % (1 << CW));
    endfunction

    // Runs one instruction starting in FETCH; dm_ready is held low for `waits` cycles of the memory state.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z, input int waits);
        int k, exp_lat, lat, dm_cnt, rf_cnt, exp_dm;
        logic e_rf;
        logic [1:0] e_wd, e_gpr, e_npc, e_alu, e_ext;
        logic e_bsel;
        k       = classify(op, fn);
        exp_lat = latency(k, waits);
        e_rf    = (k == K_ADDU || k == K_SUBU || k == K_ORI || k == K_LW || k == K_JAL);
        e_wd    = (k == K_LW) ? 2'b01 : (k == K_JAL) ? 2'b10 : 2'b00;
        e_gpr   = (k == K_ORI || k == K_LW) ? 2'b01 : (k == K_JAL) ? 2'b10 : 2'b00;
        e_npc   = (k == K_J || k == K_JAL) ? 2'b10 : (k == K_BEQ && z) ? 2'b01 : 2'b00;
        e_alu   = (k == K_SUBU || k == K_BEQ) ? 2'b01 : (k == K_ORI) ? 2'b10 : 2'b00;
        e_ext   = (k == K_LW || k == K_SW || k == K_BEQ) ? 2'b01 : 2'b00;
        e_bsel  = (k == K_ORI || k == K_LW || k == K_SW);
        exp_dm  = (k == K_SW) ? waits + 1 : 0;
        OP = op; Funct = fn; Zero = z;
        seen.delete();
        lat = 0; dm_cnt = 0; rf_cnt = 0;
        for (int c = 1; c <= exp_lat + 4 && lat == 0; c++) begin
            if ((k == K_LW || k == K_SW) && c >= 4) dm_ready = (c >= 4 + waits);
            else dm_ready = 1'($urandom);
            #1;
            seen.push_back(int'(state_o));
            if (DMWr) dm_cnt++;
            if (RFWr) rf_cnt++;
            n_tests++;
            if (RFWr && DMWr) begin
                n_fail++; $display("FAIL rf_dm_excl op=%b cycle %0d: RFWr=1 DMWr=1, need not both", op, c);
            end
            if (c == 1) begin
                n_tests++;
                if (IRWr !== 1'b1 || state_o !== 4'd0) begin
                    n_fail++; $display("FAIL fetch op=%b: IRWr=%b state=%0d, need 1/0", op, IRWr, state_o);
                end
            end
            if (c == 3 && k != K_J && k != K_JAL && k != K_ILL) begin
                n_tests++;
                if (ALUOp !== e_alu || EXTOp !== e_ext || BSel !== e_bsel) begin
                    n_fail++;
                    $display("FAIL alu_ctrl op=%b fn=%b: ALUOp=%b EXTOp=%b BSel=%b, need %b %b %b",
                             op, fn, ALUOp, EXTOp, BSel, e_alu, e_ext, e_bsel);
                end
            end
            if (PCWr === 1'b1) begin
                lat = c;
                n_tests++;
                if (RFWr !== e_rf || NPCOp !== e_npc || (e_rf && (WDSel !== e_wd || GPRSel !== e_gpr))) begin
                    n_fail++;
                    $display("FAIL final op=%b z=%b: RFWr=%b NPCOp=%b WDSel=%b GPRSel=%b, need %b %b %b %b",
                             op, z, RFWr, NPCOp, WDSel, GPRSel, e_rf, e_npc, e_wd, e_gpr);
                end
            end
            @(posedge clk); #1;
        end
        if (lat != 0) mcnt++;
        n_tests++;
        if (lat != exp_lat) begin
            n_fail++; $display("FAIL latency op=%b waits=%0d: got %0d cycles, need %0d", op, waits, lat, exp_lat);
        end
        n_tests++;
        if (dm_cnt != exp_dm || rf_cnt != (e_rf ? 1 : 0)) begin
            n_fail++; $display("FAIL strobe_count op=%b: DMWr %0d RFWr %0d cycles, need %0d %0d",
                               op, dm_cnt, rf_cnt, exp_dm, e_rf ? 1 : 0);
        end
        n_tests++;
        if (instr_cnt !== cnt_of(mcnt) || state_o !== 4'd0) begin
            n_fail++; $display("FAIL retire op=%b: instr_cnt=%0d state=%0d, need %0d 0",
                               op, instr_cnt, state_o, cnt_of(mcnt));
        end
    endtask

    task automatic check_seq(input string name, input int exp[]);
        n_tests++;
        if (seen.size() != exp.size()) begin
            n_fail++; $display("FAIL %s_len: %0d states, need %0d", name, seen.size(), exp.size());
        end else begin
            for (int i = 0; i < exp.size(); i++) begin
                n_tests++;
                if (seen[i] != exp[i]) begin
                    n_fail++; $display("FAIL %s_state[%0d]: got %0d, need %0d", name, i, seen[i], exp[i]);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; OP = 6'b100011; Funct = 6'd0; Zero = 1'b1; dm_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (state_o !== 4'd0 || instr_cnt !== '0 || halted !== 1'b0) begin
            n_fail++; $display("FAIL reset_state: state=%0d cnt=%0d halted=%b, need 0 0 0", state_o, instr_cnt, halted);
        end
        n_tests++;
        if ({PCWr, IRWr, RFWr, DMWr} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_strobes: %b, need 0000", {PCWr, IRWr, RFWr, DMWr});
        end
        rst = 1'b0; mcnt = 0;
        #1;
        n_tests++;
        if (state_o !== 4'd0 || IRWr !== 1'b1) begin
            n_fail++; $display("FAIL reset_release: state=%0d IRWr=%b, need 0 1", state_o, IRWr);
        end
    endtask

    task automatic test_addu();
        run_instr(6'b000000, 6'b100001, 1'b0, 0);
        check_seq("addu", '{0, 1, 2, 6});
    endtask

    task automatic test_lw_wait();
        run_instr(6'b100011, 6'($urandom), 1'($urandom), 2);
        check_seq("lw_wait", '{0, 1, 2, 3, 3, 3, 4});
    endtask

    task automatic test_beq();
        run_instr(6'b000100, 6'($urandom), 1'b1, 0);
        check_seq("beq_taken", '{0, 1, 7});
        run_instr(6'b000100, 6'($urandom), 1'b0, 0);
        check_seq("beq_not", '{0, 1, 7});
    endtask

    task automatic test_jal();
        run_instr(6'b000011, 6'($urandom), 1'($urandom), 0);
        check_seq("jal", '{0, 1, 8});
    endtask

    task automatic test_reset_in_mem_wr();
        OP = 6'b101011; Funct = 6'($urandom); Zero = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            dm_ready = (c >= 4) ? 1'b0 : 1'($urandom);
            @(posedge clk); #1;
        end
        n_tests++;
        if (state_o !== 4'd5 || DMWr !== 1'b1) begin
            n_fail++; $display("FAIL mem_wr_wait: state=%0d DMWr=%b, need 5 1", state_o, DMWr);
        end
        rst = 1'b1; dm_ready = 1'b1;
        #1;
        n_tests++;
        if (PCWr !== 1'b0 || DMWr !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_strobes: PCWr=%b DMWr=%b, need 0 0", PCWr, DMWr);
        end
        @(posedge clk); #1;
        rst = 1'b0; mcnt = 0;
        #1;
        n_tests++;
        if (state_o !== 4'd0 || instr_cnt !== '0) begin
            n_fail++; $display("FAIL rst_mid_after: state=%0d cnt=%0d, need 0 0", state_o, instr_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] ops[8]  = '{6'b000000, 6'b000000, 6'b001101, 6'b100011,
                                6'b101011, 6'b000100, 6'b000010, 6'b000011};
        logic [5:0] fns[8]  = '{6'b100001, 6'b100011, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0};
        for (int i = 0; i < 60; i++) begin
            int sel;
            logic [5:0] fn;
            sel = int'($urandom_range(0, 7));
            fn  = (sel < 2) ? fns[sel] : 6'($urandom);
            run_instr(ops[sel], fn, 1'($urandom), int'($urandom_range(0, 3)));
        end
    endtask

    task automatic test_illegal();
`ifdef MCTRL_ILLEGAL_TRAP_EN
        OP = 6'b111111; Funct = 6'($urandom); Zero = 1'($urandom);
        @(posedge clk); #1;
        n_tests++;
        if (state_o !== 4'd1 || PCWr !== 1'b0) begin
            n_fail++; $display("FAIL ill_decode: state=%0d PCWr=%b, need 1 0", state_o, PCWr);
        end
        @(posedge clk); #1;
        for (int c = 0; c < 10; c++) begin
            dm_ready = 1'($urandom);
            #1;
            n_tests++;
            if (state_o !== 4'd9 || halted !== 1'b1 || {PCWr, IRWr, RFWr, DMWr} !== 4'b0000
                || instr_cnt !== cnt_of(mcnt)) begin
                n_fail++;
                $display("FAIL halt[%0d]: state=%0d halted=%b strobes=%b cnt=%0d, need 9 1 0000 %0d",
                         c, state_o, halted, {PCWr, IRWr, RFWr, DMWr}, instr_cnt, cnt_of(mcnt));
            end
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; mcnt = 0;
        #1;
        n_tests++;
        if (state_o !== 4'd0 || halted !== 1'b0 || instr_cnt !== '0) begin
            n_fail++; $display("FAIL halt_reset: state=%0d halted=%b cnt=%0d, need 0 0 0", state_o, halted, instr_cnt);
        end
`else
        run_instr(6'b111111, 6'($urandom), 1'($urandom), 0);
        check_seq("illegal_nop", '{0, 1});
        n_tests++;
        if (halted !== 1'b0) begin
            n_fail++; $display("FAIL halted_tied: got %b, need 0", halted);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_addu();
        test_lw_wait();
        test_beq();
        test_jal();
        test_reset_in_mem_wr();
        test_back_to_back();
        test_illegal();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
